// File: rtl/signed_divider_pkg.sv
// signed_divider_pkg: shared ALU divider state encoding
package signed_divider_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/signed_divider_negate.sv
// twos_negate: combinational full-width two's-complement negation
module twos_negate #(
  parameter int l = 16
) (
  input  logic [l-1:0] x,
  output logic [l-1:0] y
);
  assign y = ~x + 1'b1;
endmodule

// File: rtl/signed_divider.sv
// signed_divider: multi-cycle restoring signed divider with RISC-V div-by-zero semantics
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int l = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [l-1:0] A,
  input  logic [l-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [l-1:0] Q,
  output logic [l-1:0] Rem,
  output logic         div_zero
);
  localparam int CW = $clog2(l) + 1;
  state_e state_q, state_d;
  logic sq_q, sq_d, sr_q, sr_d, bz_q, bz_d, dz_q, dz_d;
  logic [l-1:0] bm_q, bm_d, quo_q, quo_d, q_q, q_d, r_q, r_d;
  logic [l:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [l-1:0] na, nb, nq, nr, am, bm;
  logic [l:0] sh;
  logic [l+1:0] diff;
  logic go, ge, bz;
  twos_negate #(l) u_neg_a (.x(A), .y(na));
  twos_negate #(l) u_neg_b (.x(B), .y(nb));
  twos_negate #(l) u_neg_q (.x(quo_q), .y(nq));
  twos_negate #(l) u_neg_r (.x(rem_q[l-1:0]), .y(nr));
  assign am = A[l-1] ? na : A;
  assign bm = B[l-1] ? nb : B;
  assign bz = B == '0;
  assign go = start && (state_q == IDLE || state_q == DONE);
  always_comb begin
    state_d = state_q;
    sq_d = sq_q;
    sr_d = sr_q;
    bz_d = bz_q;
    dz_d = dz_q;
    bm_d = bm_q;
    quo_d = quo_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    q_d = q_q;
    r_d = r_q;
    sh = {rem_q[l-1:0], quo_q[l-1]};
    diff = {1'b0, sh} - {2'b00, bm_q};
    ge = rem_q[l] | ~diff[l+1];
    case (state_q)
      RUN: begin
        rem_d = ge ? diff[l:0] : sh;
        quo_d = {quo_q[l-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(l - 1) ? FIX : RUN;
      end
      FIX: begin
        q_d = bz_q ? '1 : (sq_q ? nq : quo_q);
        r_d = sr_q ? nr : rem_q[l-1:0];
        dz_d = bz_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (go) begin
      sq_d = A[l-1] ^ B[l-1];
      sr_d = A[l-1];
      bz_d = bz;
      bm_d = bm;
      quo_d = am;
      // For B == 0 the remainder slot carries |A| so the sign fix in FIX reproduces A exactly
      rem_d = bz ? {1'b0, am} : '0;
      cnt_d = '0;
      state_d = bz ? FIX : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sq_q <= 1'b0;
      sr_q <= 1'b0;
      bz_q <= 1'b0;
      dz_q <= 1'b0;
      bm_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      q_q <= '0;
      r_q <= '0;
    end else begin
      state_q <= state_d;
      sq_q <= sq_d;
      sr_q <= sr_d;
      bz_q <= bz_d;
      dz_q <= dz_d;
      bm_q <= bm_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      r_q <= r_d;
    end
  end
  assign busy = state_q == RUN || state_q == FIX;
  assign done = state_q == DONE;
  assign Q = q_q;
  assign Rem = r_q;
  assign div_zero = dz_q;
endmodule

// File: doc/signed_divider.md
# signed_divider

Multi-cycle signed integer divider for the 16-bit ALU. It sits downstream of the operand-conditioning logic (negation and absolute value). It converts both operands to magnitudes, runs a restoring shift-subtract loop producing one quotient bit per cycle, then restores signs with a full-width two's-complement negate. It serves the DIV/REM instruction path and follows RISC-V conventions for divide-by-zero and overflow.

## Interface
- `l`, 16, datapath width in bits (≥ 4)
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  request; sampled only when not `busy`
- `A`  input  l  dividend, signed two's complement
- `B`  input  l  divisor, signed two's complement
- `busy`  output  1  operation in progress
- `done`  output  1  one-cycle pulse; results valid
- `Q`  output  l  signed quotient
- `Rem`  output  l  signed remainder
- `div_zero`  output  1  last operation had B == 0

## Operation
- Reset values: `busy`=0, `done`=0, `Q`=0, `Rem`=0, `div_zero`=0, state IDLE.
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + `start`=1:
  - latch sign_q = A[l-1]^B[l-1] and sign_r = A[l-1];
  - latch magnitudes |A| and |B| as unsigned l-bit values (|−2^(l-1)| = 2^(l-1));
  - clear partial remainder (l+1 bits) and iteration counter;
  - go to RUN, or go straight to FIX if B == 0.
- RUN, l iterations:
  - shift {partial remainder, dividend} left by 1;
  - trial = remainder − |B|;
  - if trial ≥ 0, keep trial and set quotient LSB = 1; otherwise restore and set LSB = 0;
  - after iteration l, go to FIX.
- FIX:
  - Q = sign_q ? −quot : quot;
  - Rem = sign_r ? −rem : rem;
  - both negations are full-width (carry propagates into the MSB; −0 = 0);
  - B == 0 case: Q = all ones, Rem = A, `div_zero`=1;
  - go to DONE.
- DONE: `done`=1 for exactly this cycle. Next state is IDLE, or RUN/FIX if `start`=1 (back-to-back operations allowed).
- Overflow case −2^(l-1) / −1: Q = 0x8000, Rem = 0. This needs no special path; it falls out of the unsigned magnitudes.
- `start` while `busy`=1 is ignored. It is not queued.
- `Q`, `Rem`, `div_zero` hold their values from DONE until the next FIX.
- `rst` mid-operation: IDLE next cycle; all outputs return to reset values; the in-flight result is discarded.

## Timing
- `start` sampled at cycle 0.
- Normal case: RUN cycles 1..l, FIX cycle l+1, `done` in cycle l+2 (18 for l=16).
- Divide-by-zero: FIX cycle 1, `done` in cycle 2.
- `busy` = 1 in RUN and FIX only. It is 0 in IDLE and DONE.
- Throughput: one operation per l+2 cycles with back-to-back `start` in DONE.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Put the state encoding (2-bit IDLE=0, RUN=1, FIX=2, DONE=3) in the shared ALU defines include, alongside other ALU constants.
- Use one sub-module, `twos_negate #(l)`: a combinational full-width two's-complement negator (~x + 1 across all l bits).
  - Instantiate it for operand magnitudes (muxed on the sign bit).
  - Instantiate it for result sign correction.
- Iteration counter: clog2(l)+1 bits. Partial remainder: l+1 bits. Quotient/dividend shift register: l bits.

## Test plan
- 100 / 7 → Q=14, Rem=2, `done` exactly 18 cycles after `start`, `busy` high cycles 1–17.
- −100 / 7 → Q=0xFFF2 (−14), Rem=0xFFFE (−2). 100 / −7 → Q=0xFFF2, Rem=2.
- 7 / 0 → Q=0xFFFF, Rem=7, `div_zero`=1, `done` at cycle 2. The next valid divide clears `div_zero`.
- −32768 / −1 → Q=0x8000, Rem=0. −32768 / 1 → Q=0x8000, Rem=0. 0 / 5 → Q=0, Rem=0 (no 0x8000 artefact).
- `start` pulsed at cycle 5 of a running 100/7 with A=9, B=3 → ignored; result is still 14/2. Back-to-back `start` in the DONE cycle → second result 18 cycles later.
- `rst` asserted at cycle 8 of an operation → next cycle `busy`=0, `done`=0, Q=Rem=0. No `done` pulse follows.
